ppu_reg_file: RTL and testbench

CPU-facing PPU register file for $2000–$2007. It holds PPUCTRL, PPUMASK and OAMADDR, plus the scroll/address latches (t, v, fine_x, w toggle) and the PPUDATA read buffer. It generates the VBlank NMI and gates control writes during a parametrised power-up warm-up window. It sits between the CPU bus decoder and the PPU rendering/VRAM/OAM logic.

---
 rtl/ppu_reg_file.sv | 149 ++++++++++++++
 tb/tb_ppu_reg_file.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_reg_file.sv
// CPU-facing PPU register window ($2000-$2007): control/mask/OAM address, scroll and
// VRAM address latches, PPUDATA read buffer, status flags, VBlank NMI and warm-up gating.
module ppu_reg_file #(
    parameter int WARMUP_CYCLES = 29658,
    parameter int V_WIDTH       = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         cpu_addr,
    input  logic               cpu_wr_en,
    input  logic               cpu_rd_en,
    input  logic [7:0]         cpu_data_in,
    output logic [7:0]         cpu_data_out,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               sprite0_hit_set,
    input  logic               sprite_ovf_set,
    output logic [7:0]         ppuctrl_out,
    output logic [7:0]         ppumask_out,
    output logic [2:0]         fine_x,
    output logic [V_WIDTH-1:0] t_addr,
    output logic [13:0]        vram_addr,
    output logic               vram_rd_en,
    output logic               vram_wr_en,
    output logic [7:0]         vram_wr_data,
    input  logic [7:0]         vram_rd_data,
    output logic [7:0]         oam_addr,
    output logic               oam_wr_en,
    output logic               nmi,
    output logic               warmup_done
);
    localparam int CW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WC = CW'(WARMUP_CYCLES);

    logic [7:0]         r_ctrl, r_mask, r_oam_addr, r_oam_wr_addr, r_rd_buf, r_io_latch, r_dout;
    logic [7:0]         r_vram_wr_data;
    logic [V_WIDTH-1:0] r_t, r_v;
    logic [13:0]        r_acc_addr;
    logic [2:0]         r_fine_x;
    logic               r_w, r_vblank, r_s0, r_ovf, r_nmi;
    logic               r_vram_rd_en, r_vram_wr_en, r_oam_wr_en, r_rd_pend;
    logic [CW-1:0]      r_cnt;

    logic               w_warm, w_rd, w_gated, w_live, w_rd2002;
    logic [V_WIDTH-1:0] w_inc;

    assign w_warm   = (r_cnt == WC);
    assign w_rd     = cpu_rd_en & ~cpu_wr_en;
    assign w_gated  = (cpu_addr == 3'd0) | (cpu_addr == 3'd1) | (cpu_addr == 3'd5) | (cpu_addr == 3'd6);
    assign w_live   = w_warm | ~w_gated;
    assign w_rd2002 = w_rd & (cpu_addr == 3'd2);
    assign w_inc    = r_ctrl[2] ? V_WIDTH'(32) : V_WIDTH'(1);

    assign cpu_data_out = r_dout;
    assign ppuctrl_out  = r_ctrl;
    assign ppumask_out  = r_mask;
    assign fine_x       = r_fine_x;
    assign t_addr       = r_t;
    // During a strobe the buses show the address of the access, not the already-advanced one
    assign vram_addr    = (r_vram_rd_en | r_vram_wr_en) ? r_acc_addr : r_v[13:0];
    assign oam_addr     = r_oam_wr_en ? r_oam_wr_addr : r_oam_addr;
    assign vram_rd_en   = r_vram_rd_en;
    assign vram_wr_en   = r_vram_wr_en;
    assign vram_wr_data = r_vram_wr_data;
    assign oam_wr_en    = r_oam_wr_en;
    assign nmi          = r_nmi;
    assign warmup_done  = w_warm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0; r_mask <= '0; r_oam_addr <= '0; r_oam_wr_addr <= '0;
            r_rd_buf <= '0; r_io_latch <= '0; r_dout <= '0; r_vram_wr_data <= '0;
            r_t <= '0; r_v <= '0; r_acc_addr <= '0; r_fine_x <= '0; r_w <= 1'b0;
            r_vblank <= 1'b0; r_s0 <= 1'b0; r_ovf <= 1'b0; r_nmi <= 1'b0;
            r_vram_rd_en <= 1'b0; r_vram_wr_en <= 1'b0; r_oam_wr_en <= 1'b0;
            r_rd_pend <= 1'b0; r_cnt <= '0;
        end else begin
            r_vram_rd_en <= 1'b0;
            r_vram_wr_en <= 1'b0;
            r_oam_wr_en  <= 1'b0;
            // VRAM data arrives the cycle after the read strobe
            r_rd_pend    <= r_vram_rd_en;
            if (r_rd_pend) r_rd_buf <= vram_rd_data;
            if (!w_warm) r_cnt <= r_cnt + 1'b1;
            r_nmi    <= r_vblank & r_ctrl[7];
            r_vblank <= vblank_set | (r_vblank & ~vblank_clr & ~w_rd2002);
            r_s0     <= sprite0_hit_set | (r_s0 & ~vblank_clr);
            r_ovf    <= sprite_ovf_set | (r_ovf & ~vblank_clr);

            if (cpu_wr_en) begin
                r_io_latch <= cpu_data_in;
                case (cpu_addr)
                    3'd0: if (w_live) begin
                        r_ctrl      <= cpu_data_in;
                        r_t[11:10]  <= cpu_data_in[1:0];
                    end
                    3'd1: if (w_live) r_mask <= cpu_data_in;
                    3'd3: r_oam_addr <= cpu_data_in;
                    3'd4: begin
                        r_oam_wr_en   <= 1'b1;
                        r_oam_wr_addr <= r_oam_addr;
                        r_oam_addr    <= r_oam_addr + 8'd1;
                    end
                    3'd5: if (w_live) begin
                        if (!r_w) begin
                            r_t[4:0] <= cpu_data_in[7:3];
                            r_fine_x <= cpu_data_in[2:0];
                        end else begin
                            r_t[14:12] <= cpu_data_in[2:0];
                            r_t[9:5]   <= cpu_data_in[7:3];
                        end
                        r_w <= ~r_w;
                    end
                    3'd6: if (w_live) begin
                        if (!r_w) begin
                            r_t[13:8] <= cpu_data_in[5:0];
                            r_t[14]   <= 1'b0;
                        end else begin
                            r_t[7:0] <= cpu_data_in;
                            r_v      <= {r_t[V_WIDTH-1:8], cpu_data_in};
                        end
                        r_w <= ~r_w;
                    end
                    3'd7: begin
                        r_vram_wr_en   <= 1'b1;
                        r_vram_wr_data <= cpu_data_in;
                        r_acc_addr     <= r_v[13:0];
                        r_v            <= r_v + w_inc;
                    end
                    default: ;
                endcase
            end else if (cpu_rd_en) begin
                case (cpu_addr)
                    3'd2: begin
                        r_dout <= {r_vblank, r_s0, r_ovf, r_io_latch[4:0]};
                        r_w    <= 1'b0;
                    end
                    3'd7: begin
                        r_dout       <= r_rd_buf;
                        r_vram_rd_en <= 1'b1;
                        r_acc_addr   <= r_v[13:0];
                        r_v          <= r_v + w_inc;
                    end
                    default: r_dout <= r_io_latch;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ppu_reg_file.sv
// Directed plus randomized bench for ppu_reg_file against a per-cycle behavioural model
// with a small VRAM device that answers read strobes one cycle late.
module tb_ppu_reg_file;
    localparam int WU = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  cpu_addr = '0;
    logic        cpu_wr_en = 1'b0, cpu_rd_en = 1'b0;
    logic [7:0]  cpu_data_in = '0, cpu_data_out;
    logic        vblank_set = 1'b0, vblank_clr = 1'b0, sprite0_hit_set = 1'b0, sprite_ovf_set = 1'b0;
    logic [7:0]  ppuctrl_out, ppumask_out, vram_wr_data, oam_addr;
    logic [7:0]  vram_rd_data = '0;
    logic [2:0]  fine_x;
    logic [14:0] t_addr;
    logic [13:0] vram_addr;
    logic        vram_rd_en, vram_wr_en, oam_wr_en, nmi, warmup_done;

    ppu_reg_file #(.WARMUP_CYCLES(WU), .V_WIDTH(15)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .vblank_set(vblank_set),
        .vblank_clr(vblank_clr), .sprite0_hit_set(sprite0_hit_set), .sprite_ovf_set(sprite_ovf_set),
        .ppuctrl_out(ppuctrl_out), .ppumask_out(ppumask_out), .fine_x(fine_x), .t_addr(t_addr),
        .vram_addr(vram_addr), .vram_rd_en(vram_rd_en), .vram_wr_en(vram_wr_en),
        .vram_wr_data(vram_wr_data), .vram_rd_data(vram_rd_data), .oam_addr(oam_addr),
        .oam_wr_en(oam_wr_en), .nmi(nmi), .warmup_done(warmup_done));

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= rst ? 0 : edge_cnt + 1;

    // VRAM device: answers a read strobe with data during the following cycle only
    logic [7:0]  mem [0:16383];
    logic [7:0]  ref_mem [0:16383];
    bit          dev_pend = 1'b0;
    logic [13:0] dev_addr = '0;
    always @(negedge clk) begin
        if (dev_pend) vram_rd_data = mem[dev_addr];
        else          vram_rd_data = 8'($urandom);
        dev_pend = vram_rd_en;
        dev_addr = vram_addr;
        if (vram_wr_en) mem[vram_addr] = vram_wr_data;
    end

    int errors = 0, checks = 0;

    logic [7:0]  m_ctrl, m_mask, m_oam, m_buf, m_io, m_dout;
    logic [14:0] m_t, m_v;
    logic [13:0] m_acc;
    logic [2:0]  m_fx;
    bit          m_w, m_vb, m_s0, m_ov;
    int          m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_mask = 0; m_oam = 0; m_buf = 0; m_io = 0; m_dout = 0;
        m_t = 0; m_v = 0; m_acc = 0; m_fx = 0; m_w = 0; m_vb = 0; m_s0 = 0; m_ov = 0; m_pend = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dout"}, cpu_data_out, 0);  chk({tag, "_ctrl"}, ppuctrl_out, 0);
        chk({tag, "_mask"}, ppumask_out, 0);   chk({tag, "_fx"}, fine_x, 0);
        chk({tag, "_t"}, t_addr, 0);           chk({tag, "_vaddr"}, vram_addr, 0);
        chk({tag, "_strobes"}, {vram_rd_en, vram_wr_en, oam_wr_en}, 0);
        chk({tag, "_oam"}, oam_addr, 0);       chk({tag, "_nmi"}, nmi, 0);
        chk({tag, "_warm"}, warmup_done, 0);
    endtask

    // One clock cycle: drive inputs, advance the model, check every visible output after the edge
    task automatic op(input bit wr, input bit rd, input logic [2:0] a, input logic [7:0] d,
                      input bit vs = 0, input bit vc = 0, input bit s0 = 0, input bit ov = 0);
        logic [7:0]  e_dout, e_so, e_wd;
        logic [13:0] e_sa;
        logic [14:0] inc;
        bit          rdv, live, e_nmi, e_vwr, e_vrd, e_owr;
        rdv   = rd && !wr;
        live  = (edge_cnt >= WU) || !(a inside {3'd0, 3'd1, 3'd5, 3'd6});
        inc   = m_ctrl[2] ? 15'd32 : 15'd1;
        e_vwr = 0; e_vrd = 0; e_owr = 0; e_sa = 0; e_so = 0; e_wd = 0;
        e_nmi = m_vb & m_ctrl[7];
        e_dout = m_dout;
        if (rdv) begin
            if (a == 3'd2)      e_dout = {m_vb, m_s0, m_ov, m_io[4:0]};
            else if (a == 3'd7) e_dout = m_buf;
            else                e_dout = m_io;
        end
        if (m_pend == 1) m_buf = ref_mem[m_acc];
        if (m_pend > 0) m_pend--;
        if (wr) begin
            m_io = d;
            case (a)
                3'd0: if (live) begin m_ctrl = d; m_t[11:10] = d[1:0]; end
                3'd1: if (live) m_mask = d;
                3'd3: m_oam = d;
                3'd4: begin e_owr = 1; e_so = m_oam; m_oam = m_oam + 8'd1; end
                3'd5: if (live) begin
                    if (!m_w) begin m_t[4:0] = d[7:3]; m_fx = d[2:0]; end
                    else begin m_t[14:12] = d[2:0]; m_t[9:5] = d[7:3]; end
                    m_w = !m_w;
                end
                3'd6: if (live) begin
                    if (!m_w) begin m_t[13:8] = d[5:0]; m_t[14] = 1'b0; end
                    else begin m_t[7:0] = d; m_v = m_t; end
                    m_w = !m_w;
                end
                3'd7: begin
                    e_vwr = 1; e_sa = m_v[13:0]; e_wd = d;
                    ref_mem[m_v[13:0]] = d; m_v = m_v + inc;
                end
                default: ;
            endcase
        end else if (rdv) begin
            if (a == 3'd2) m_w = 0;
            if (a == 3'd7) begin
                e_vrd = 1; e_sa = m_v[13:0]; m_acc = m_v[13:0]; m_pend = 2; m_v = m_v + inc;
            end
        end
        m_vb = vs | (m_vb & !vc & !(rdv && a == 3'd2));
        m_s0 = s0 | (m_s0 & !vc);
        m_ov = ov | (m_ov & !vc);
        m_dout = e_dout;

        cpu_wr_en = wr; cpu_rd_en = rd; cpu_addr = a; cpu_data_in = d;
        vblank_set = vs; vblank_clr = vc; sprite0_hit_set = s0; sprite_ovf_set = ov;
        @(posedge clk);
        @(negedge clk);
        cpu_wr_en = 0; cpu_rd_en = 0; vblank_set = 0; vblank_clr = 0;
        sprite0_hit_set = 0; sprite_ovf_set = 0;

        chk("cpu_data_out", cpu_data_out, e_dout);
        chk("vram_wr_en", vram_wr_en, e_vwr);
        chk("vram_rd_en", vram_rd_en, e_vrd);
        chk("vram_addr", vram_addr, (e_vwr | e_vrd) ? e_sa : m_v[13:0]);
        if (e_vwr) chk("vram_wr_data", vram_wr_data, e_wd);
        chk("oam_wr_en", oam_wr_en, e_owr);
        chk("oam_addr", oam_addr, e_owr ? e_so : m_oam);
        chk("ppuctrl", ppuctrl_out, m_ctrl);
        chk("ppumask", ppumask_out, m_mask);
        chk("fine_x", fine_x, m_fx);
        chk("t_addr", t_addr, m_t);
        chk("nmi", nmi, e_nmi);
        chk("warmup_done", warmup_done, edge_cnt >= WU);
    endtask

    task automatic idle(input int n = 1);
        for (int i = 0; i < n; i++) op(0, 0, 3'd0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 0;

        // Warm-up window: gated registers ignore writes, others stay live
        idle(4);
        op(1, 0, 3'd0, 8'h80);
        op(1, 0, 3'd5, 8'hFF);
        op(1, 0, 3'd1, 8'h1E);
        op(1, 0, 3'd3, 8'h12);
        while (edge_cnt < 19) idle();
        op(1, 0, 3'd0, 8'h80);
        op(1, 0, 3'd0, 8'h00);

        // $2006 address load then $2007 write, +1 increment
        op(1, 0, 3'd6, 8'h21); op(1, 0, 3'd6, 8'h08);
        op(1, 0, 3'd7, 8'h55); idle();

        // +32 increment across the 14-bit boundary
        op(1, 0, 3'd0, 8'h04);
        op(1, 0, 3'd6, 8'h3F); op(1, 0, 3'd6, 8'hF0);
        op(1, 0, 3'd7, 8'hA1); op(1, 0, 3'd7, 8'hA2); idle();
        op(1, 0, 3'd0, 8'h00);

        // Scroll writes, then $2002 resets the toggle
        op(1, 0, 3'd5, 8'h7D); op(1, 0, 3'd5, 8'h5E);
        op(0, 1, 3'd2, 8'h00); op(1, 0, 3'd5, 8'h00);

        // NMI raised by enabling it inside VBlank, dropped by the status read
        op(0, 0, 3'd0, 8'h00, 1);
        op(1, 0, 3'd0, 8'h80); idle(2);
        op(0, 1, 3'd2, 8'h00); idle(2);
        op(1, 0, 3'd0, 8'h00);

        // Status read racing vblank_set; set beats clear; sprite flags
        op(0, 1, 3'd2, 8'h00, 1); idle();
        op(0, 1, 3'd2, 8'h00);
        op(0, 0, 3'd0, 8'h00, 0, 0, 1, 1);
        op(0, 1, 3'd2, 8'h00);
        op(0, 0, 3'd0, 8'h00, 1, 1, 1, 1);
        op(0, 1, 3'd2, 8'h00);
        op(0, 0, 3'd0, 8'h00, 0, 1);
        op(0, 1, 3'd2, 8'h00);

        // OAM address wrap
        op(1, 0, 3'd3, 8'hFF); op(1, 0, 3'd4, 8'h11); op(1, 0, 3'd4, 8'h22); idle();
        op(0, 1, 3'd4, 8'h00);

        // Simultaneous read and write: write wins, data out holds
        op(1, 1, 3'd1, 8'h3C);
        op(1, 1, 3'd2, 8'h9F);
        op(0, 1, 3'd2, 8'h00);

        // Buffered $2007 reads spaced two cycles apart
        op(1, 0, 3'd6, 8'h01); op(1, 0, 3'd6, 8'h23);
        op(0, 1, 3'd7, 8'h00); idle(2);
        op(0, 1, 3'd7, 8'h00); idle(2);
        op(0, 1, 3'd7, 8'h00); idle(2);

        // Randomized traffic
        begin
            int cool = 0;
            for (int i = 0; i < 400; i++) begin
                if (cool > 0) begin
                    idle(); cool--;
                end else begin
                    int r = $urandom_range(0, 9);
                    logic [2:0] a = 3'($urandom_range(0, 7));
                    bit wr = (r < 5) || (r == 9);
                    bit rd = (r >= 5);
                    op(wr, rd, a, 8'($urandom), $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                    if (rd && !wr && a == 3'd7) cool = 2;
                end
            end
        end

        // Asynchronous reset in the middle of a cycle
        op(1, 0, 3'd3, 8'h5A);
        #2 rst = 1;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst = 0;
        model_reset();
        op(1, 0, 3'd0, 8'h80);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
